// File: rtl/counter_ctrl_pkg.sv
// Shared types and default widths for the counter run controller and its helpers.
// Imported by the controller top and the wait timer.
package counter_ctrl_pkg;

  localparam int DEF_CNT_W        = 5;
  localparam int DEF_RUN_W        = 4;
  localparam int DEF_BUSY_TIMEOUT = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_GAP,
    ST_START,
    ST_WAIT_BUSY,
    ST_RUN,
    ST_DRAIN,
    ST_REPORT
  } ctrl_state_e;

  typedef enum logic [1:0] {
    STATUS_MAX     = 2'd0,
    STATUS_ABORT   = 2'd1,
    STATUS_TIMEOUT = 2'd2
  } run_status_e;

endpackage

// File: rtl/ctrl_wait_timer.sv
// Loadable up-counter that saturates at LIMIT; expiring is high during the
// enabled cycle whose edge would bring the count to LIMIT.
module ctrl_wait_timer
  import counter_ctrl_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int LIMIT = DEF_BUSY_TIMEOUT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             enable,
  output logic             expiring
);

  logic [WIDTH-1:0] count;

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (enable && (count != WIDTH'(LIMIT))) begin
      count <= count + 1'b1;
    end
  end

  assign expiring = enable && (count == WIDTH'(LIMIT - 1));

endmodule

// File: rtl/counter_run_controller.sv
// Initiator for the counter start/flag/busy/count_value interface: runs a job of
// N back-to-back count runs and returns one result record over a valid/ready port.
module counter_run_controller
  import counter_ctrl_pkg::*;
#(
  parameter int CNT_W        = DEF_CNT_W,
  parameter int RUN_W        = DEF_RUN_W,
  parameter int TOT_W        = CNT_W + RUN_W,
  parameter int BUSY_TIMEOUT = DEF_BUSY_TIMEOUT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_abort_en,
  input  logic [CNT_W-1:0] req_abort_at,
  input  logic [RUN_W-1:0] req_runs,
  output logic             start,
  output logic             flag,
  input  logic             busy,
  input  logic [CNT_W-1:0] count_value,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [1:0]       rsp_status,
  output logic [CNT_W-1:0] rsp_last_count,
  output logic [TOT_W-1:0] rsp_total,
  output logic [RUN_W-1:0] rsp_runs_done
);

  localparam int TMR_W = $clog2(BUSY_TIMEOUT + 1);

  ctrl_state_e state, next_state;
  run_status_e status, status_nxt;

  logic             abort_en_q;
  logic [CNT_W-1:0] abort_at_q;
  logic [RUN_W-1:0] runs_left;
  logic [RUN_W-1:0] runs_done, runs_done_nxt;
  logic [CNT_W-1:0] last_count;
  logic [TOT_W-1:0] total, total_nxt;

  logic accept, abort_hit, run_done, last_run, timeout_hit, timer_expiring;
  logic start_d, flag_d, rsp_valid_d, report_entry;

  assign req_ready    = (state == ST_IDLE);
  assign accept       = req_valid && req_ready;
  assign abort_hit    = (state == ST_RUN) && abort_en_q && busy && (count_value == abort_at_q);
  assign run_done     = ((state == ST_RUN) || (state == ST_DRAIN)) && !busy;
  assign last_run     = (runs_left == RUN_W'(1));
  assign timeout_hit  = (state == ST_WAIT_BUSY) && !busy && timer_expiring;
  assign report_entry = (next_state == ST_REPORT) && (state != ST_REPORT);

  ctrl_wait_timer #(
    .WIDTH (TMR_W),
    .LIMIT (BUSY_TIMEOUT)
  ) u_wait_timer (
    .clk        (clk),
    .rst        (rst),
    .load       (state == ST_START),
    .load_value ('0),
    .enable     (state == ST_WAIT_BUSY),
    .expiring   (timer_expiring)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    unique case (state)
      ST_IDLE:      if (accept) next_state = ST_GAP;
      ST_GAP:       if (!busy) next_state = ST_START;
      ST_START:     next_state = ST_WAIT_BUSY;
      ST_WAIT_BUSY: begin
        if (busy) begin
          next_state = ST_RUN;
        end else if (timer_expiring) begin
          next_state = ST_REPORT;
        end
      end
      ST_RUN: begin
        if (abort_hit) begin
          next_state = ST_DRAIN;
        end else if (!busy) begin
          next_state = last_run ? ST_REPORT : ST_GAP;
        end
      end
      ST_DRAIN:     if (!busy) next_state = last_run ? ST_REPORT : ST_GAP;
      ST_REPORT:    if (rsp_ready) next_state = ST_IDLE;
      default:      next_state = ST_IDLE;
    endcase
  end

  // Next values of the registered outputs and of the per-job accumulators,
  // so the response record can be loaded with the totals of the final run.
  always_comb begin
    start_d       = (next_state == ST_START);
    flag_d        = abort_hit;
    rsp_valid_d   = (next_state == ST_REPORT);
    status_nxt    = status;
    total_nxt     = total;
    runs_done_nxt = runs_done;
    if (state == ST_START) status_nxt = STATUS_MAX;
    if (abort_hit)         status_nxt = STATUS_ABORT;
    if (timeout_hit)       status_nxt = STATUS_TIMEOUT;
    if (run_done) begin
      total_nxt     = total + TOT_W'(last_count);
      runs_done_nxt = runs_done + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      start          <= 1'b0;
      flag           <= 1'b0;
      rsp_valid      <= 1'b0;
      rsp_status     <= STATUS_MAX;
      rsp_last_count <= '0;
      rsp_total      <= '0;
      rsp_runs_done  <= '0;
      status         <= STATUS_MAX;
      abort_en_q     <= 1'b0;
      abort_at_q     <= '0;
      runs_left      <= '0;
      runs_done      <= '0;
      last_count     <= '0;
      total          <= '0;
    end else begin
      start     <= start_d;
      flag      <= flag_d;
      rsp_valid <= rsp_valid_d;
      status    <= status_nxt;

      if (accept) begin
        abort_en_q <= req_abort_en;
        abort_at_q <= req_abort_at;
        runs_left  <= (req_runs == '0) ? RUN_W'(1) : req_runs;
        runs_done  <= '0;
        total      <= '0;
      end else begin
        runs_done <= runs_done_nxt;
        total     <= total_nxt;
        if (run_done) runs_left <= runs_left - 1'b1;
      end

      // The first busy cycle is seen in WAIT_BUSY, so capture there as well.
      if (state == ST_START) begin
        last_count <= '0;
      end else if (busy && ((state == ST_WAIT_BUSY) || (state == ST_RUN) || (state == ST_DRAIN))) begin
        last_count <= count_value;
      end

      if (report_entry) begin
        rsp_status     <= status_nxt;
        rsp_last_count <= last_count;
        rsp_total      <= total_nxt;
        rsp_runs_done  <= runs_done_nxt;
      end
    end
  end

endmodule

// File: tb/tb_counter_run_controller.sv
// Directed bench for counter_run_controller with a behavioural counter responder
// that clears on the start edge, counts once per busy cycle and stops at max or on flag.
module tb_counter_run_controller;

  localparam int CNT_W = 5;
  localparam int RUN_W = 4;
  localparam int TOT_W = CNT_W + RUN_W;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             req_valid = 1'b0;
  logic             req_ready;
  logic             req_abort_en = 1'b0;
  logic [CNT_W-1:0] req_abort_at = '0;
  logic [RUN_W-1:0] req_runs = '0;
  logic             start;
  logic             flag;
  logic             busy = 1'b0;
  logic [CNT_W-1:0] count_value = '0;
  logic             rsp_valid;
  logic             rsp_ready = 1'b0;
  logic [1:0]       rsp_status;
  logic [CNT_W-1:0] rsp_last_count;
  logic [TOT_W-1:0] rsp_total;
  logic [RUN_W-1:0] rsp_runs_done;

  int errors = 0;
  int checks = 0;

  logic mute_busy = 1'b0;
  logic start_prev = 1'b0;

  int   start_pulses = 0;
  int   start_bad = 0;
  int   flag_pulses = 0;
  int   flag_long = 0;
  logic mon_start_q = 1'b0;
  logic mon_busy_q = 1'b0;
  logic mon_flag_q = 1'b0;

  counter_run_controller dut (
    .clk            (clk),
    .rst            (rst),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_abort_en   (req_abort_en),
    .req_abort_at   (req_abort_at),
    .req_runs       (req_runs),
    .start          (start),
    .flag           (flag),
    .busy           (busy),
    .count_value    (count_value),
    .rsp_valid      (rsp_valid),
    .rsp_ready      (rsp_ready),
    .rsp_status     (rsp_status),
    .rsp_last_count (rsp_last_count),
    .rsp_total      (rsp_total),
    .rsp_runs_done  (rsp_runs_done)
  );

  always #5 clk = ~clk;

  // Counter responder; deliberately not reset by rst so it finishes on its own.
  always @(posedge clk) begin
    start_prev <= start;
    if (start && !start_prev && !mute_busy) begin
      busy        <= 1'b1;
      count_value <= '0;
    end else if (busy) begin
      if (flag || count_value == 5'd31) busy <= 1'b0;
      else count_value <= count_value + 1'b1;
    end
  end

  always @(negedge clk) begin
    if (start && !mon_start_q) begin
      start_pulses <= start_pulses + 1;
      if (mon_busy_q) start_bad <= start_bad + 1;
    end
    if (flag && !mon_flag_q) flag_pulses <= flag_pulses + 1;
    if (flag && mon_flag_q) flag_long <= flag_long + 1;
    mon_start_q <= start;
    mon_busy_q  <= busy;
    mon_flag_q  <= flag;
  end

  task automatic send_req(input logic [RUN_W-1:0] runs, input logic en, input logic [CNT_W-1:0] at);
    @(negedge clk);
    req_valid    = 1'b1;
    req_runs     = runs;
    req_abort_en = en;
    req_abort_at = at;
    for (int i = 0; i < 20 && !req_ready; i++) @(negedge clk);
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic wait_rsp(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (rsp_valid) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic ack_rsp();
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++; if (start !== 1'b0) begin errors++; $display("[TB] FAIL reset_start: got %b expected 0", start); end
    checks++; if (flag !== 1'b0) begin errors++; $display("[TB] FAIL reset_flag: got %b expected 0", flag); end
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_rsp_valid: got %b expected 0", rsp_valid); end
    checks++; if (req_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_req_ready: got %b expected 1", req_ready); end
    checks++; if (rsp_status !== 2'd0) begin errors++; $display("[TB] FAIL reset_status: got %0d expected 0", rsp_status); end
    checks++; if (rsp_last_count !== 5'd0) begin errors++; $display("[TB] FAIL reset_last: got %0d expected 0", rsp_last_count); end
    checks++; if (rsp_total !== 9'd0) begin errors++; $display("[TB] FAIL reset_total: got %0d expected 0", rsp_total); end
    checks++; if (rsp_runs_done !== 4'd0) begin errors++; $display("[TB] FAIL reset_runs_done: got %0d expected 0", rsp_runs_done); end
  endtask

  task automatic test_max_run();
    bit ok;
    int s0 = start_pulses;
    int f0 = flag_pulses;
    send_req(4'd1, 1'b0, 5'd10);
    wait_rsp(300, ok);
    checks++; if (!ok) begin errors++; $display("[TB] FAIL max_rsp_timeout: got no rsp_valid expected rsp_valid"); end
    checks++; if (rsp_status !== 2'd0) begin errors++; $display("[TB] FAIL max_status: got %0d expected 0", rsp_status); end
    checks++; if (rsp_last_count !== 5'd31) begin errors++; $display("[TB] FAIL max_last: got %0d expected 31", rsp_last_count); end
    checks++; if (rsp_total !== 9'd31) begin errors++; $display("[TB] FAIL max_total: got %0d expected 31", rsp_total); end
    checks++; if (rsp_runs_done !== 4'd1) begin errors++; $display("[TB] FAIL max_runs_done: got %0d expected 1", rsp_runs_done); end
    checks++; if (start_pulses - s0 != 1) begin errors++; $display("[TB] FAIL max_start_pulses: got %0d expected 1", start_pulses - s0); end
    checks++; if (flag_pulses - f0 != 0) begin errors++; $display("[TB] FAIL max_flag_pulses: got %0d expected 0", flag_pulses - f0); end
    ack_rsp();
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("[TB] FAIL max_rsp_drop: got %b expected 0", rsp_valid); end
    checks++; if (req_ready !== 1'b1) begin errors++; $display("[TB] FAIL max_ready_back: got %b expected 1", req_ready); end
  endtask

  task automatic test_abort_single();
    bit ok;
    int f0 = flag_pulses;
    int l0 = flag_long;
    send_req(4'd1, 1'b1, 5'd10);
    wait_rsp(300, ok);
    checks++; if (!ok) begin errors++; $display("[TB] FAIL abort_rsp_timeout: got no rsp_valid expected rsp_valid"); end
    checks++; if (rsp_status !== 2'd1) begin errors++; $display("[TB] FAIL abort_status: got %0d expected 1", rsp_status); end
    checks++; if (rsp_last_count !== 5'd11) begin errors++; $display("[TB] FAIL abort_last: got %0d expected 11", rsp_last_count); end
    checks++; if (rsp_total !== 9'd11) begin errors++; $display("[TB] FAIL abort_total: got %0d expected 11", rsp_total); end
    checks++; if (flag_pulses - f0 != 1) begin errors++; $display("[TB] FAIL abort_flag_pulses: got %0d expected 1", flag_pulses - f0); end
    checks++; if (flag_long - l0 != 0) begin errors++; $display("[TB] FAIL abort_flag_width: got %0d extra cycles expected 0", flag_long - l0); end
    ack_rsp();
  endtask

  task automatic test_back_to_back();
    bit ok;
    int s0 = start_pulses;
    int b0 = start_bad;
    int f0 = flag_pulses;
    send_req(4'd3, 1'b1, 5'd5);
    wait_rsp(400, ok);
    checks++; if (!ok) begin errors++; $display("[TB] FAIL b2b_rsp_timeout: got no rsp_valid expected rsp_valid"); end
    checks++; if (rsp_status !== 2'd1) begin errors++; $display("[TB] FAIL b2b_status: got %0d expected 1", rsp_status); end
    checks++; if (rsp_last_count !== 5'd6) begin errors++; $display("[TB] FAIL b2b_last: got %0d expected 6", rsp_last_count); end
    checks++; if (rsp_total !== 9'd18) begin errors++; $display("[TB] FAIL b2b_total: got %0d expected 18", rsp_total); end
    checks++; if (rsp_runs_done !== 4'd3) begin errors++; $display("[TB] FAIL b2b_runs_done: got %0d expected 3", rsp_runs_done); end
    checks++; if (start_pulses - s0 != 3) begin errors++; $display("[TB] FAIL b2b_start_pulses: got %0d expected 3", start_pulses - s0); end
    checks++; if (start_bad - b0 != 0) begin errors++; $display("[TB] FAIL b2b_start_while_busy: got %0d expected 0", start_bad - b0); end
    checks++; if (flag_pulses - f0 != 3) begin errors++; $display("[TB] FAIL b2b_flag_pulses: got %0d expected 3", flag_pulses - f0); end
    ack_rsp();
  endtask

  task automatic test_abort_at_max();
    bit ok;
    send_req(4'd2, 1'b1, 5'd31);
    wait_rsp(400, ok);
    checks++; if (!ok) begin errors++; $display("[TB] FAIL atmax_rsp_timeout: got no rsp_valid expected rsp_valid"); end
    checks++; if (rsp_status !== 2'd1) begin errors++; $display("[TB] FAIL atmax_status: got %0d expected 1", rsp_status); end
    checks++; if (rsp_last_count !== 5'd31) begin errors++; $display("[TB] FAIL atmax_last: got %0d expected 31", rsp_last_count); end
    checks++; if (rsp_total !== 9'd62) begin errors++; $display("[TB] FAIL atmax_total: got %0d expected 62", rsp_total); end
    checks++; if (rsp_runs_done !== 4'd2) begin errors++; $display("[TB] FAIL atmax_runs_done: got %0d expected 2", rsp_runs_done); end
    ack_rsp();
  endtask

  task automatic test_zero_runs();
    bit ok;
    int s0 = start_pulses;
    int f0 = flag_pulses;
    send_req(4'd0, 1'b0, 5'd3);
    wait_rsp(300, ok);
    checks++; if (!ok) begin errors++; $display("[TB] FAIL zero_rsp_timeout: got no rsp_valid expected rsp_valid"); end
    checks++; if (rsp_status !== 2'd0) begin errors++; $display("[TB] FAIL zero_status: got %0d expected 0", rsp_status); end
    checks++; if (rsp_runs_done !== 4'd1) begin errors++; $display("[TB] FAIL zero_runs_done: got %0d expected 1", rsp_runs_done); end
    checks++; if (rsp_total !== 9'd31) begin errors++; $display("[TB] FAIL zero_total: got %0d expected 31", rsp_total); end
    checks++; if (start_pulses - s0 != 1) begin errors++; $display("[TB] FAIL zero_start_pulses: got %0d expected 1", start_pulses - s0); end
    checks++; if (flag_pulses - f0 != 0) begin errors++; $display("[TB] FAIL zero_flag_pulses: got %0d expected 0", flag_pulses - f0); end
    ack_rsp();
  endtask

  task automatic test_timeout();
    int s0 = start_pulses;
    int gap = -1;
    mute_busy = 1'b1;
    send_req(4'd3, 1'b0, 5'd0);
    for (int i = 0; i < 20 && !start; i++) @(negedge clk);
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (rsp_valid) begin
        gap = k;
        break;
      end
    end
    checks++; if (gap != 9) begin errors++; $display("[TB] FAIL timeout_latency: got %0d cycles expected 9", gap); end
    checks++; if (rsp_status !== 2'd2) begin errors++; $display("[TB] FAIL timeout_status: got %0d expected 2", rsp_status); end
    checks++; if (rsp_runs_done !== 4'd0) begin errors++; $display("[TB] FAIL timeout_runs_done: got %0d expected 0", rsp_runs_done); end
    checks++; if (rsp_total !== 9'd0) begin errors++; $display("[TB] FAIL timeout_total: got %0d expected 0", rsp_total); end
    checks++; if (rsp_last_count !== 5'd0) begin errors++; $display("[TB] FAIL timeout_last: got %0d expected 0", rsp_last_count); end
    checks++; if (start_pulses - s0 != 1) begin errors++; $display("[TB] FAIL timeout_start_pulses: got %0d expected 1", start_pulses - s0); end
    ack_rsp();
    mute_busy = 1'b0;
  endtask

  task automatic test_reset_mid_run();
    bit ok;
    bit saw_rsp = 1'b0;
    send_req(4'd1, 1'b0, 5'd0);
    for (int i = 0; i < 20 && !busy; i++) @(negedge clk);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++; if (start !== 1'b0) begin errors++; $display("[TB] FAIL midrst_start: got %b expected 0", start); end
    checks++; if (flag !== 1'b0) begin errors++; $display("[TB] FAIL midrst_flag: got %b expected 0", flag); end
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("[TB] FAIL midrst_rsp_valid: got %b expected 0", rsp_valid); end
    checks++; if (req_ready !== 1'b1) begin errors++; $display("[TB] FAIL midrst_req_ready: got %b expected 1", req_ready); end
    rst = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (rsp_valid) saw_rsp = 1'b1;
    end
    checks++; if (saw_rsp) begin errors++; $display("[TB] FAIL midrst_no_rsp: got rsp_valid expected none"); end
    send_req(4'd1, 1'b1, 5'd7);
    wait_rsp(300, ok);
    checks++; if (!ok) begin errors++; $display("[TB] FAIL midrst_fresh_timeout: got no rsp_valid expected rsp_valid"); end
    checks++; if (rsp_status !== 2'd1) begin errors++; $display("[TB] FAIL midrst_fresh_status: got %0d expected 1", rsp_status); end
    checks++; if (rsp_last_count !== 5'd8) begin errors++; $display("[TB] FAIL midrst_fresh_last: got %0d expected 8", rsp_last_count); end
    checks++; if (rsp_total !== 9'd8) begin errors++; $display("[TB] FAIL midrst_fresh_total: got %0d expected 8", rsp_total); end
    ack_rsp();
  endtask

  task automatic test_rsp_hold();
    bit ok;
    int s0;
    send_req(4'd1, 1'b1, 5'd2);
    wait_rsp(300, ok);
    checks++; if (!ok) begin errors++; $display("[TB] FAIL hold_rsp_timeout: got no rsp_valid expected rsp_valid"); end
    s0 = start_pulses;
    req_valid    = 1'b1;
    req_runs     = 4'd1;
    req_abort_en = 1'b0;
    req_abort_at = 5'd0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      checks++; if (rsp_valid !== 1'b1) begin errors++; $display("[TB] FAIL hold_valid c%0d: got %b expected 1", c, rsp_valid); end
      checks++; if (req_ready !== 1'b0) begin errors++; $display("[TB] FAIL hold_req_ready c%0d: got %b expected 0", c, req_ready); end
      checks++; if (rsp_status !== 2'd1 || rsp_last_count !== 5'd3 || rsp_total !== 9'd3 || rsp_runs_done !== 4'd1)
        begin errors++; $display("[TB] FAIL hold_fields c%0d: got %0d/%0d/%0d/%0d expected 1/3/3/1", c, rsp_status, rsp_last_count, rsp_total, rsp_runs_done); end
    end
    checks++; if (start_pulses - s0 != 0) begin errors++; $display("[TB] FAIL hold_no_new_job: got %0d starts expected 0", start_pulses - s0); end
    ack_rsp();
    checks++; if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin errors++; $display("[TB] FAIL hold_handshake: got ready=%b valid=%b expected 1/0", req_ready, rsp_valid); end
    @(negedge clk);
    req_valid = 1'b0;
    checks++; if (req_ready !== 1'b0) begin errors++; $display("[TB] FAIL hold_new_accept: got %b expected 0", req_ready); end
    wait_rsp(300, ok);
    checks++; if (!ok || rsp_status !== 2'd0 || rsp_total !== 9'd31) begin errors++; $display("[TB] FAIL hold_next_job: got ok=%0d status=%0d total=%0d expected 1/0/31", ok, rsp_status, rsp_total); end
    ack_rsp();
  endtask

  initial begin
    test_reset();
    test_max_run();
    test_abort_single();
    test_back_to_back();
    test_abort_at_max();
    test_zero_runs();
    test_timeout();
    test_reset_mid_run();
    test_rsp_hold();
    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
